iaaa_control_unit: RTL and testbench

- Microsequencer for the IAAA processor.
- Runs fetch/decode/execute by driving the register-file write decoder (20 lines), the read mux, the ALU op code, PC increment and the memory strobes.
- The opcode comes back from the instruction register, which latches MIDR[15:12] when write line 19 is selected.
- Sits between the memory interface and the datapath. It is the only source of write-select in the core.

---
 rtl/iaaa_ctrl_pkg.sv | 99 +++++++++
 rtl/iaaa_control_unit_if.sv | 13 +
 rtl/iaaa_mem_wait.sv | 33 +++
 rtl/iaaa_control_unit.sv | 117 +++++++++++
 tb/tb_iaaa_control_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/iaaa_ctrl_pkg.sv
// Shared definitions for the IAAA microsequencer.
// Holds the state encoding, opcodes, register-file indices, ALU codes and the
// registered control-word layout with its per-state decode.
package iaaa_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE  = 4'd0;
    localparam state_t ST_F_AR  = 4'd1;
    localparam state_t ST_F_MEM = 4'd2;
    localparam state_t ST_F_IR  = 4'd3;
    localparam state_t ST_DEC   = 4'd4;
    localparam state_t ST_X_AR  = 4'd5;
    localparam state_t ST_X_MRD = 4'd6;
    localparam state_t ST_X_WB  = 4'd7;
    localparam state_t ST_X_MWR = 4'd8;
    localparam state_t ST_X_ALU = 4'd9;
    localparam state_t ST_X_JMP = 4'd10;
    localparam state_t ST_HALT  = 4'd11;
    localparam state_t ST_ERR   = 4'd12;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_INC   = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_JMPZ  = 4'd7;
    localparam logic [3:0] OP_END   = 4'd15;

    localparam logic [4:0] REG_AR   = 5'd0;
    localparam logic [4:0] REG_PC   = 5'd1;
    localparam logic [4:0] REG_AC   = 5'd2;
    localparam logic [4:0] REG_R    = 5'd3;
    localparam logic [4:0] REG_MIDR = 5'd18;
    localparam logic [4:0] REG_IR   = 5'd19;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_INC  = 3'd3;

    typedef struct packed {
        logic       wr_en;
        logic [4:0] wr_sel;
        logic [4:0] rd_sel;
        logic [2:0] alu_op;
        logic       pc_inc;
        logic       mem_rd;
        logic       mem_wr;
        logic       busy;
        logic       done;
        logic       error;
    } ctrl_t;

    function automatic logic [2:0] alu_of(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_INC:  return ALU_INC;
            default: return ALU_PASS;
        endcase
    endfunction

    // Control word belonging to a state; op only matters for X_ALU.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [3:0] op);
        ctrl_t c;
        c      = '0;
        c.busy = 1'b1;
        case (st)
            ST_F_AR:  begin c.wr_en = 1'b1; c.wr_sel = REG_AR; c.rd_sel = REG_PC; end
            ST_F_MEM: c.mem_rd = 1'b1;
            ST_F_IR:  begin
                c.wr_en  = 1'b1;
                c.wr_sel = REG_IR;
                c.rd_sel = REG_MIDR;
                c.pc_inc = 1'b1;
            end
            ST_DEC:   c.busy = 1'b1;
            ST_X_AR:  begin c.wr_en = 1'b1; c.wr_sel = REG_AR; c.rd_sel = REG_MIDR; end
            ST_X_MRD: c.mem_rd = 1'b1;
            ST_X_WB:  begin c.wr_en = 1'b1; c.wr_sel = REG_AC; c.rd_sel = REG_MIDR; end
            ST_X_MWR: begin c.mem_wr = 1'b1; c.rd_sel = REG_AC; end
            ST_X_ALU: begin
                c.wr_en  = 1'b1;
                c.wr_sel = REG_AC;
                c.rd_sel = REG_R;
                c.alu_op = alu_of(op);
            end
            ST_X_JMP: begin c.wr_en = 1'b1; c.wr_sel = REG_PC; c.rd_sel = REG_MIDR; end
            ST_HALT:  begin c.busy = 1'b0; c.done = 1'b1; end
            ST_ERR:   begin c.busy = 1'b0; c.error = 1'b1; end
            default:  c.busy = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/iaaa_control_unit_if.sv
// Memory handshake between the microsequencer (master) and the memory
// interface (slave).
//   Mem_rd    : read request, address from AR
//   Mem_wr    : write request, address AR, data from MDR
//   Mem_ready : read data valid in MIDR / write accepted, this cycle
interface iaaa_control_unit_if;
    logic Mem_rd;
    logic Mem_wr;
    logic Mem_ready;

    modport master (output Mem_rd, output Mem_wr, input Mem_ready);
    modport slave (input Mem_rd, input Mem_wr, output Mem_ready);
endinterface

// File: rtl/iaaa_mem_wait.sv
// Memory wait counter shared by every state that waits on Mem_ready.
//   Clock, Reset : core clock, synchronous active-high reset
//   start        : a wait state is active this cycle
//   clear        : memory answered this cycle
//   timeout      : this is the last cycle the request may stay unanswered
module iaaa_mem_wait #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic start,
    input  logic clear,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;

    // Counter holds the number of cycles already spent waiting; it saturates.
    always_ff @(posedge Clock) begin
        if (Reset || clear || !start) begin
            cnt_q <= '0;
        end else if (cnt_q != MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout = start && (cnt_q >= LAST);

endmodule

// File: rtl/iaaa_control_unit.sv
// IAAA microsequencer: fetch/decode/execute driving the register-file write
// decoder, read mux, ALU op, PC increment and memory strobes.
//   Clock, Reset  : core clock, synchronous active-high reset
//   Start         : level start in IDLE, rising edge restarts from HALT
//   IR_out        : opcode from the instruction register
//   Z_flag        : registered ALU zero flag
//   mem_bus       : Mem_rd / Mem_wr / Mem_ready handshake
//   WR_en, WR_sel : write strobe and register index
//   RD_sel        : register driven onto the bus
//   ALU_op, PC_inc: datapath controls
//   Busy, Done, Error : status
// All outputs are registered from the next state, so they line up with the
// state they belong to.
module iaaa_control_unit
    import iaaa_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [3:0]           IR_out,
    input  logic                 Z_flag,
    iaaa_control_unit_if.master  mem_bus,
    output logic                 WR_en,
    output logic [4:0]           WR_sel,
    output logic [4:0]           RD_sel,
    output logic [2:0]           ALU_op,
    output logic                 PC_inc,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Error
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   start_q;
    logic   wait_active;
    logic   timeout;

    assign wait_active = (state_q == ST_F_MEM) || (state_q == ST_X_MRD) ||
                         (state_q == ST_X_MWR);

    iaaa_mem_wait #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_mem_wait (
        .Clock   (Clock),
        .Reset   (Reset),
        .start   (wait_active),
        .clear   (mem_bus.Mem_ready),
        .timeout (timeout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (Start) state_d = ST_F_AR;
            ST_F_AR:  state_d = ST_F_MEM;
            ST_F_MEM: begin
                if (mem_bus.Mem_ready) state_d = ST_F_IR;
                else if (timeout)      state_d = ST_ERR;
            end
            ST_F_IR:  state_d = ST_DEC;
            ST_DEC: begin
                case (IR_out)
                    OP_NOP:                 state_d = ST_F_AR;
                    OP_LOAD, OP_STORE:      state_d = ST_X_AR;
                    OP_ADD, OP_SUB, OP_INC: state_d = ST_X_ALU;
                    OP_JMP:                 state_d = ST_X_JMP;
                    OP_JMPZ:                state_d = Z_flag ? ST_X_JMP : ST_F_AR;
                    OP_END:                 state_d = ST_HALT;
                    default:                state_d = ST_F_AR; // reserved opcodes
                endcase
            end
            // IR is not rewritten during execute, so the opcode is still valid here.
            ST_X_AR:  state_d = (IR_out == OP_STORE) ? ST_X_MWR : ST_X_MRD;
            ST_X_MRD: begin
                if (mem_bus.Mem_ready) state_d = ST_X_WB;
                else if (timeout)      state_d = ST_ERR;
            end
            ST_X_MWR: begin
                if (mem_bus.Mem_ready) state_d = ST_F_AR;
                else if (timeout)      state_d = ST_ERR;
            end
            ST_X_WB, ST_X_ALU, ST_X_JMP: state_d = ST_F_AR;
            ST_HALT:  if (Start && !start_q) state_d = ST_F_AR;
            ST_ERR:   state_d = ST_ERR;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d, IR_out);
            start_q <= Start;
        end
    end

    assign WR_en          = ctrl_q.wr_en;
    assign WR_sel         = ctrl_q.wr_sel;
    assign RD_sel         = ctrl_q.rd_sel;
    assign ALU_op         = ctrl_q.alu_op;
    assign PC_inc         = ctrl_q.pc_inc;
    assign mem_bus.Mem_rd = ctrl_q.mem_rd;
    assign mem_bus.Mem_wr = ctrl_q.mem_wr;
    assign Busy           = ctrl_q.busy;
    assign Done           = ctrl_q.done;
    assign Error          = ctrl_q.error;

endmodule

// File: tb/tb_iaaa_control_unit.sv
module tb_iaaa_control_unit;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic [3:0] IR_out;
    logic       Z_flag;
    logic       WR_en;
    logic [4:0] WR_sel;
    logic [4:0] RD_sel;
    logic [2:0] ALU_op;
    logic       PC_inc;
    logic       Busy;
    logic       Done;
    logic       Error;

    iaaa_control_unit_if mif ();

    iaaa_control_unit #(
        .MEM_TIMEOUT (15),
        .CNT_W       (8)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .IR_out  (IR_out),
        .Z_flag  (Z_flag),
        .mem_bus (mif),
        .WR_en   (WR_en),
        .WR_sel  (WR_sel),
        .RD_sel  (RD_sel),
        .ALU_op  (ALU_op),
        .PC_inc  (PC_inc),
        .Busy    (Busy),
        .Done    (Done),
        .Error   (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string      name;
        logic [19:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // {WR_en, WR_sel, RD_sel, ALU_op, PC_inc, Mem_rd, Mem_wr, Busy, Done, Error}
    function automatic logic [19:0] mk(input logic we, input logic [4:0] ws,
                                       input logic [4:0] rs, input logic [2:0] alu,
                                       input logic pc, input logic mr, input logic mw,
                                       input logic bsy, input logic dn, input logic er);
        return {we, ws, rs, alu, pc, mr, mw, bsy, dn, er};
    endfunction

    logic [19:0] E_IDLE, E_F_AR, E_F_MEM, E_F_IR, E_DEC, E_X_AR, E_X_MRD, E_X_WB;
    logic [19:0] E_X_MWR, E_ADD, E_SUB, E_INC, E_X_JMP, E_HALT, E_ERR;

    task automatic step(input string nm, input logic [19:0] e);
        exp_t it;
        @(posedge Clock);
        it.name = nm;
        it.v    = e;
        sb.push_back(it);
        #1;
    endtask

    // From an F_AR cycle: one-cycle memory fetch, ends in the DEC cycle of op.
    task automatic fetch(input logic [3:0] op);
        mif.Mem_ready = 1'b0;
        step("f_mem", E_F_MEM);
        mif.Mem_ready = 1'b1;
        step("f_ir", E_F_IR);
        mif.Mem_ready = 1'b0;
        IR_out = op;
        step("dec", E_DEC);
    endtask

    always @(negedge Clock) begin
        if (sb.size() > 0) begin
            exp_t it;
            logic [19:0] act;
            it  = sb.pop_front();
            act = {WR_en, WR_sel, RD_sel, ALU_op, PC_inc, mif.Mem_rd, mif.Mem_wr,
                   Busy, Done, Error};
            checks++;
            if (act !== it.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", it.name, act, it.v, $time);
            end
        end
    end

    initial begin
        repeat (2000) @(posedge Clock);
        errors++;
        $display("FAIL watchdog: stimulus did not complete within 2000 cycles");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        E_IDLE  = '0;
        E_F_AR  = mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        E_F_MEM = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        E_F_IR  = mk(1, 19, 18, 0, 1, 0, 0, 1, 0, 0);
        E_DEC   = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        E_X_AR  = mk(1, 0, 18, 0, 0, 0, 0, 1, 0, 0);
        E_X_MRD = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        E_X_WB  = mk(1, 2, 18, 0, 0, 0, 0, 1, 0, 0);
        E_X_MWR = mk(0, 0, 2, 0, 0, 0, 1, 1, 0, 0);
        E_ADD   = mk(1, 2, 3, 1, 0, 0, 0, 1, 0, 0);
        E_SUB   = mk(1, 2, 3, 2, 0, 0, 0, 1, 0, 0);
        E_INC   = mk(1, 2, 3, 3, 0, 0, 0, 1, 0, 0);
        E_X_JMP = mk(1, 1, 18, 0, 0, 0, 0, 1, 0, 0);
        E_HALT  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        E_ERR   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        Reset = 1'b1; Start = 1'b0; IR_out = 4'h3; Z_flag = 1'b0; mif.Mem_ready = 1'b0;
        step("reset", E_IDLE);
        step("reset", E_IDLE);
        checks++;
        if (Busy !== 1'b0 || mif.Mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_direct: Busy=%b Mem_rd=%b", Busy, mif.Mem_rd);
        end
        Reset = 1'b0;
        step("idle", E_IDLE);

        // ADD with memory answering on the second F_MEM cycle.
        Start = 1'b1;
        step("add_f_ar", E_F_AR);
        Start = 1'b0;
        step("add_f_mem1", E_F_MEM);
        step("add_f_mem2", E_F_MEM);
        mif.Mem_ready = 1'b1;
        step("add_f_ir", E_F_IR);
        mif.Mem_ready = 1'b0;
        step("add_dec", E_DEC);
        step("add_x_alu", E_ADD);
        checks++;
        if (ALU_op !== 3'd1 || WR_sel !== 5'd2 || WR_en !== 1'b1) begin
            errors++;
            $display("FAIL add_direct: ALU_op=%0d WR_sel=%0d WR_en=%b", ALU_op, WR_sel, WR_en);
        end
        step("add_back_f_ar", E_F_AR);

        fetch(4'h4); step("sub_x_alu", E_SUB); step("sub_f_ar", E_F_AR);
        fetch(4'h5); step("inc_x_alu", E_INC); step("inc_f_ar", E_F_AR);

        Z_flag = 1'b0;
        fetch(4'h7); step("jmpz0_f_ar", E_F_AR);
        Z_flag = 1'b1;
        fetch(4'h7); step("jmpz1_x_jmp", E_X_JMP);
        checks++;
        if (WR_sel !== 5'd1 || RD_sel !== 5'd18 || WR_en !== 1'b1) begin
            errors++;
            $display("FAIL jmpz_direct: WR_sel=%0d RD_sel=%0d WR_en=%b", WR_sel, RD_sel, WR_en);
        end
        step("jmpz1_f_ar", E_F_AR);
        Z_flag = 1'b0;
        fetch(4'h6); step("jmp_x_jmp", E_X_JMP); step("jmp_f_ar", E_F_AR);
        fetch(4'h0); step("nop_f_ar", E_F_AR);

        // Reserved opcode, with a stray Mem_ready outside any wait state.
        fetch(4'hA);
        mif.Mem_ready = 1'b1;
        step("rsv_f_ar", E_F_AR);
        step("rsv_stray_ready_f_mem", E_F_MEM);
        step("rsv_f_ir", E_F_IR);
        mif.Mem_ready = 1'b0;
        IR_out = 4'h1;
        step("load_dec", E_DEC);
        step("load_x_ar", E_X_AR);
        step("load_x_mrd1", E_X_MRD);
        step("load_x_mrd2", E_X_MRD);
        mif.Mem_ready = 1'b1;
        step("load_x_wb", E_X_WB);
        mif.Mem_ready = 1'b0;
        step("load_f_ar", E_F_AR);

        fetch(4'h2);
        step("store_x_ar", E_X_AR);
        step("store_x_mwr", E_X_MWR);
        mif.Mem_ready = 1'b1;
        step("store_f_ar", E_F_AR);
        mif.Mem_ready = 1'b0;

        // Reset while F_MEM is waiting with Mem_rd high.
        step("rst_mid_f_mem", E_F_MEM);
        Reset = 1'b1;
        step("rst_mid_idle", E_IDLE);
        Reset = 1'b0;
        step("rst_mid_stay_idle", E_IDLE);

        // END, then Start 1 -> 0 -> 1 restarts fetch.
        Start = 1'b1;
        step("end_f_ar", E_F_AR);
        fetch(4'hF);
        step("end_halt", E_HALT);
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL halt_direct: Done=%b Busy=%b", Done, Busy);
        end
        step("halt_start_held", E_HALT);
        Start = 1'b0;
        step("halt_start_low", E_HALT);
        step("halt_start_low2", E_HALT);
        Start = 1'b1;
        step("halt_restart_f_ar", E_F_AR);
        checks++;
        if (WR_sel !== 5'd0 || WR_en !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL restart_direct: WR_sel=%0d WR_en=%b Done=%b", WR_sel, WR_en, Done);
        end
        Start = 1'b0;

        // STORE with memory never answering: 15 Mem_wr cycles, then ERR.
        fetch(4'h2);
        step("to_x_ar", E_X_AR);
        for (int i = 0; i < 15; i++) step($sformatf("to_x_mwr_%0d", i + 1), E_X_MWR);
        step("to_err", E_ERR);
        checks++;
        if (Error !== 1'b1 || mif.Mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL err_direct: Error=%b Mem_wr=%b", Error, mif.Mem_wr);
        end
        Start = 1'b1;
        step("err_hold_start", E_ERR);
        Start = 1'b0;
        step("err_hold", E_ERR);
        step("err_hold2", E_ERR);
        Reset = 1'b1;
        step("err_reset", E_IDLE);
        Reset = 1'b0;
        step("err_reset_idle", E_IDLE);

        @(negedge Clock);
        #1;
        if (checks < 12) begin
            errors++;
            $display("FAIL too few checks: %0d", checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
